mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Parametrised, iterative multiply/divide unit with architectural HI/LO registers.
- Executes MULT, MULTU, DIV, DIVU over multiple cycles and serves MFHI/MFLO reads.
- Sits beside the single-cycle ALU in the execute stage. The control unit issues a start pulse and stalls on busy.
- Successor to the fixed 32-bit MULTU/DIVU path: width is parametrised, signed ops are supported, and there is a start/busy/done handshake.

Parameters:
- WIDTH, 32, operand width in bits; HI and LO are each WIDTH bits; must be >= 4 and even.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not to be overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; accepted only when busy=0.
- op  in  md_op_t (2)  MD_MULT, MD_MULTU, MD_DIV or MD_DIVU; sampled with start.
- a  in  WIDTH  rs operand (multiplicand / dividend); sampled with start.
- b  in  WIDTH  rt operand (multiplier / divisor); sampled with start.
- busy  out  1  high while an operation is in flight.
- done  out  1  single-cycle pulse on the cycle HI/LO take the result.
- hi  out  WIDTH  HI register (product upper half / remainder).
- lo  out  WIDTH  LO register (product lower half / quotient).

Behaviour:
- Reset: state=IDLE; busy=0; done=0; hi=0; lo=0; counter=0. Reset mid-operation abandons the operation and leaves HI/LO=0.
- FSM states: IDLE, CALC, FINISH.
- IDLE:
  - start=1 latches op, |a|, |b| (absolute values for signed ops, raw values for unsigned) and the sign flags, then moves to CALC.
  - For DIV/DIVU with b=0: see Optional Feature.
- CALC: exactly WIDTH cycles, one bit per cycle.
  - Multiply: radix-2 shift-add into a 2*WIDTH accumulator.
  - Divide: restoring division producing quotient and remainder.
  - Counter counts WIDTH-1 down to 0; at 0 the FSM goes to FINISH.
- FINISH:
  - Sign fix-up: product negated if sign(a)^sign(b) for MULT; quotient negated if sign(a)^sign(b) for DIV; remainder takes the sign of a for DIV.
  - Write HI/LO, assert done for this cycle only, return to IDLE.
- Latency: start accepted at edge t; done=1 and new hi/lo visible in cycle t+WIDTH+1. That is WIDTH+1 cycles in flight (33 for WIDTH=32).
- busy = (state != IDLE). It is high in the cycle after start is accepted, through the FINISH cycle.
- start while busy=1 is ignored: no queueing and no error.
- start in the FINISH cycle is ignored. A new start is legal in the first IDLE cycle after done.
- hi/lo hold their previous values throughout CALC. MFHI/MFLO read the outputs directly; the control unit must stall while busy.
- Signed overflow: DIV of the most-negative value by -1 gives lo = most-negative and hi=0 (wraps), with no exception.
- Arithmetic is modulo 2^WIDTH per half. Unsigned ops never apply sign fix-up.

Optional Feature:
- Macro: MUL_DIV_DIVZERO_EN.
- Defined:
  - Adds output div_by_zero (1 bit, reset 0).
  - DIV/DIVU with b=0 skips CALC: IDLE -> FINISH directly, so done arrives at t+1.
  - HI/LO stay unchanged; div_by_zero=1 together with done for one cycle.
- Undefined:
  - No extra port; the divide runs the full WIDTH cycles.
  - Restoring-divider natural result: lo = all-ones, hi = |a| with sign fix-up applied.

Decomposition:
- global_types package gains: typedef enum logic [1:0] md_op_t {MD_MULT=2'b00, MD_MULTU=2'b01, MD_DIV=2'b10, MD_DIVU=2'b11}, plus state enum md_state_t {MD_IDLE, MD_CALC, MD_FINISH}.
- Existing alu_ctrl_t MULTUac/DIVUac/MFHIac/MFLOac map onto md_op_t in the control unit, not here.
- One natural sub-module: md_sign_fix (combinational; abs on entry, conditional negate on exit), instanced twice.

Test Plan (WIDTH=32):
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done at cycle t+33; hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 33 cycles.
- MULT a=-3 (0xFFFFFFFD), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIVU a=100, b=7 -> lo=14, hi=2. DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
- Start DIVU 100/7, assert start with MULTU 2*3 at cycles t+5 and t+33 (FINISH) -> both ignored; result lo=14, hi=2; only one done pulse.
- MULTU 6*7, assert rst at t+10 -> hi=lo=0, busy=0, no done. Start 6*7 after reset -> lo=42 at +33.
- DIVU 5/0: macro defined -> done at t+1, div_by_zero=1, hi/lo unchanged. Undefined -> done at t+33, lo=0xFFFFFFFF, hi=5.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg
//   Shared types for the iterative multiply/divide unit: the operation
//   encoding issued by the control unit, the FSM state encoding, and small
//   helpers that decode an operation into its divide/signed attributes.
package mul_div_unit_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_t;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_CALC,
        MD_FINISH
    } md_state_t;

    function automatic logic op_is_div(md_op_t op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(md_op_t op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if
//   Request/result bundle between the control unit (master) and the
//   multiply/divide unit (slave).
//   start/op/a/b : request, sampled with start while the unit is idle
//   busy/done    : operation in flight / one-cycle result pulse
//   hi/lo        : architectural HI/LO registers
//   div_by_zero  : only when MUL_DIV_DIVZERO_EN is defined
interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    import mul_div_unit_pkg::*;

    logic             start;
    md_op_t           op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
`ifdef MUL_DIV_DIVZERO_EN
    logic             div_by_zero;

    modport master (output start, op, a, b, input busy, done, hi, lo, div_by_zero);
    modport slave  (input start, op, a, b, output busy, done, hi, lo, div_by_zero);
`else
    modport master (output start, op, a, b, input busy, done, hi, lo);
    modport slave  (input start, op, a, b, output busy, done, hi, lo);
`endif
endinterface

// File: rtl/mul_div_unit_sign_fix.sv
// md_sign_fix
//   Combinational conditional negation of a pair of W-bit values.
//   Used on entry to take absolute values of the operands and on exit to
//   restore the sign of the result.
//   hi_i/lo_i          : input pair
//   join_i             : 1 = treat {hi_i,lo_i} as one 2W-bit value negated by neg_lo_i
//                        0 = negate each half independently
//   neg_hi_i/neg_lo_i  : per-half negate requests
//   hi_o/lo_o          : result pair
module md_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] hi_i,
    input  logic [W-1:0] lo_i,
    input  logic         join_i,
    input  logic         neg_hi_i,
    input  logic         neg_lo_i,
    output logic [W-1:0] hi_o,
    output logic [W-1:0] lo_o
);
    logic [2*W-1:0] pair_neg;

    // NOTE: combinational logic uses blocking assignments so later
    // statements see the values computed earlier in the same block.
    always_comb begin
        pair_neg = -{hi_i, lo_i};
        if (join_i) begin
            {hi_o, lo_o} = neg_lo_i ? pair_neg : {hi_i, lo_i};
        end else begin
            hi_o = neg_hi_i ? -hi_i : hi_i;
            lo_o = neg_lo_i ? -lo_i : lo_i;
        end
    end
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit
//   Iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO
//   registers. One result bit per cycle: radix-2 shift-add multiply and
//   restoring divide on magnitudes, with the sign restored in FINISH.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   md   : mul_div_unit_if.slave (start/op/a/b in, busy/done/hi/lo out)
//   Optional build macro MUL_DIV_DIVZERO_EN: divide by zero skips CALC,
//   leaves HI/LO untouched and raises div_by_zero with done.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    mul_div_unit_if.slave    md
);
    md_state_t          state_q, state_d;
    md_op_t             op_q;
    logic [2*WIDTH-1:0] acc_q;      // {HI-half, LO-half} working register
    logic [WIDTH-1:0]   opnd_q;     // multiplicand or divisor magnitude
    logic [CNT_W-1:0]   cnt_q;
    logic               neg_hi_q, neg_lo_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               skip_write;

    logic               a_neg, b_neg, b_zero;
    logic [WIDTH-1:0]   a_abs, b_abs, res_hi, res_lo;
    logic [WIDTH:0]     mul_sum;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] step_next;

    assign a_neg  = op_is_signed(md.op) & md.a[WIDTH-1];
    assign b_neg  = op_is_signed(md.op) & md.b[WIDTH-1];
    assign b_zero = (md.b == '0);

    md_sign_fix #(.W(WIDTH)) u_abs (
        .hi_i(md.a), .lo_i(md.b), .join_i(1'b0),
        .neg_hi_i(a_neg), .neg_lo_i(b_neg),
        .hi_o(a_abs), .lo_o(b_abs)
    );

    // Multiply negates the full product; divide fixes quotient and remainder separately.
    md_sign_fix #(.W(WIDTH)) u_fix (
        .hi_i(acc_q[2*WIDTH-1:WIDTH]), .lo_i(acc_q[WIDTH-1:0]),
        .join_i(~op_is_div(op_q)),
        .neg_hi_i(neg_hi_q), .neg_lo_i(neg_lo_q),
        .hi_o(res_hi), .lo_o(res_lo)
    );

`ifdef MUL_DIV_DIVZERO_EN
    logic dbz_q;
    assign skip_write = dbz_q;
`else
    assign skip_write = 1'b0;
`endif

    // One iteration. Multiply: add multiplicand to the upper half when the
    // current multiplier bit is set, then shift right. Divide: shift the
    // partial remainder left, subtract the divisor if it fits and shift the
    // quotient bit into the bottom. The difference always fits WIDTH bits
    // when div_ge holds, since the shifted remainder is below 2*divisor.
    always_comb begin
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_ge  = (acc_q[2*WIDTH-1:WIDTH-1] >= {1'b0, opnd_q});
        div_rem = acc_q[2*WIDTH-2:WIDTH-1] - opnd_q;
        if (op_is_div(op_q)) begin
            step_next = div_ge ? {div_rem, acc_q[WIDTH-2:0], 1'b1}
                               : {acc_q[2*WIDTH-2:0], 1'b0};
        end else begin
            step_next = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    // NOTE: clocked state is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) state_q <= MD_IDLE;
        else     state_q <= state_d;
    end

    // NOTE: the default assignment first keeps every path driven, so no
    // latch is inferred when a case arm leaves state_d untouched.
    always_comb begin
        state_d = state_q;
        case (state_q)
            MD_IDLE: begin
                if (md.start) begin
`ifdef MUL_DIV_DIVZERO_EN
                    if (op_is_div(md.op) && b_zero) state_d = MD_FINISH;
                    else                            state_d = MD_CALC;
`else
                    state_d = MD_CALC;
`endif
                end
            end
            MD_CALC:   if (cnt_q == '0) state_d = MD_FINISH;
            MD_FINISH: state_d = MD_IDLE;
            default:   state_d = MD_IDLE;
        endcase
    end

    always_comb begin
        md.busy = (state_q != MD_IDLE);
        md.done = (state_q == MD_FINISH);
        md.hi   = (md.done && !skip_write) ? res_hi : hi_q;
        md.lo   = (md.done && !skip_write) ? res_lo : lo_q;
`ifdef MUL_DIV_DIVZERO_EN
        md.div_by_zero = md.done && dbz_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= MD_MULT;
            acc_q    <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            neg_hi_q <= 1'b0;
            neg_lo_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
`ifdef MUL_DIV_DIVZERO_EN
            dbz_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (md.start) begin
                        op_q  <= md.op;
                        cnt_q <= CNT_W'(WIDTH - 1);
                        if (op_is_div(md.op)) begin
                            acc_q    <= {{WIDTH{1'b0}}, a_abs};
                            opnd_q   <= b_abs;
                            neg_lo_q <= a_neg ^ b_neg;
                            neg_hi_q <= a_neg;          // remainder follows dividend
                        end else begin
                            acc_q    <= {{WIDTH{1'b0}}, b_abs};
                            opnd_q   <= a_abs;
                            neg_lo_q <= a_neg ^ b_neg;
                            neg_hi_q <= a_neg ^ b_neg;
                        end
`ifdef MUL_DIV_DIVZERO_EN
                        dbz_q <= op_is_div(md.op) && b_zero;
`endif
                    end
                end
                MD_CALC: begin
                    acc_q <= step_next;
                    if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                end
                MD_FINISH: begin
                    if (!skip_write) begin
                        hi_q <= res_hi;
                        lo_q <= res_lo;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit
//   Directed bench for mul_div_unit at WIDTH=32. Cycle index k counts falling
//   edges after the edge that accepted start; k=1 is the first busy cycle and
//   done is expected at k=33 (k=1 for a skipped divide by zero).
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    mul_div_unit_if #(.WIDTH(32)) md_bus ();

    mul_div_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .md  (md_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one operation and watches a 40-cycle window. inj1/inj2 raise
    // start (with MULTU 2*3 on the bus) at those indices; rst_cyc pulses reset.
    task automatic run_op(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                          input int inj1, input int inj2, input int rst_cyc,
                          input logic [31:0] prev_hi, input logic [31:0] prev_lo,
                          output int done_at, output int n_done, output int n_busy,
                          output int n_hold_err, output logic [31:0] hi_at,
                          output logic [31:0] lo_at, output logic dbz_at);
        done_at = -1; n_done = 0; n_busy = 0; n_hold_err = 0;
        hi_at = '0; lo_at = '0; dbz_at = 1'b0;
        @(negedge clk);
        md_bus.start = 1'b1; md_bus.op = op; md_bus.a = a; md_bus.b = b;
        @(negedge clk);
        md_bus.start = 1'b0; md_bus.op = MD_MULTU; md_bus.a = 32'd2; md_bus.b = 32'd3;
        for (int k = 1; k <= 40; k++) begin
            if (md_bus.busy) n_busy++;
            if (md_bus.done) begin
                n_done++;
                if (done_at < 0) begin
                    done_at = k; hi_at = md_bus.hi; lo_at = md_bus.lo;
`ifdef MUL_DIV_DIVZERO_EN
                    dbz_at = md_bus.div_by_zero;
`endif
                end
            end else if (md_bus.busy && (md_bus.hi !== prev_hi || md_bus.lo !== prev_lo)) begin
                n_hold_err++;
            end
            md_bus.start = (k == inj1) || (k == inj2);
            rst = (k == rst_cyc);
            @(negedge clk);
        end
        md_bus.start = 1'b0;
        rst = 1'b0;
    endtask

    int          d_at, n_d, n_b, n_h;
    logic [31:0] r_hi, r_lo;
    logic        r_dbz;

    task automatic test_reset();
        rst = 1'b1; md_bus.start = 1'b0; md_bus.op = MD_MULT; md_bus.a = '0; md_bus.b = '0;
        repeat (3) @(negedge clk);
        vectors++; if (md_bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", md_bus.busy); end
        vectors++; if (md_bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", md_bus.done); end
        vectors++; if (md_bus.hi !== 32'h0) begin miscompares++; $display("FAIL reset_hi: got %h want 0", md_bus.hi); end
        vectors++; if (md_bus.lo !== 32'h0) begin miscompares++; $display("FAIL reset_lo: got %h want 0", md_bus.lo); end
        rst = 1'b0;
    endtask

    // Common result checks for a single complete operation.
    task automatic check_result(input string name, input int exp_at, input int exp_busy,
                                input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        vectors++; if (d_at !== exp_at) begin miscompares++; $display("FAIL %s_latency: got %0d want %0d", name, d_at, exp_at); end
        vectors++; if (n_d !== 1) begin miscompares++; $display("FAIL %s_done_count: got %0d want 1", name, n_d); end
        vectors++; if (n_b !== exp_busy) begin miscompares++; $display("FAIL %s_busy_cycles: got %0d want %0d", name, n_b, exp_busy); end
        vectors++; if (n_h !== 0) begin miscompares++; $display("FAIL %s_hold: got %0d changes want 0", name, n_h); end
        vectors++; if (r_hi !== exp_hi) begin miscompares++; $display("FAIL %s_hi: got %h want %h", name, r_hi, exp_hi); end
        vectors++; if (r_lo !== exp_lo) begin miscompares++; $display("FAIL %s_lo: got %h want %h", name, r_lo, exp_lo); end
    endtask

    task automatic test_multiply();
        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, -1, 32'h0, 32'h0,
               d_at, n_d, n_b, n_h, r_hi, r_lo, r_dbz);
        check_result("multu_max", 33, 33, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op(MD_MULT, 32'hFFFF_FFFD, 32'd5, -1, -1, -1, 32'hFFFF_FFFE, 32'h0000_0001,
               d_at, n_d, n_b, n_h, r_hi, r_lo, r_dbz);
        check_result("mult_neg", 33, 33, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    endtask

    task automatic test_divide();
        run_op(MD_DIVU, 32'd100, 32'd7, -1, -1, -1, 32'hFFFF_FFFF, 32'hFFFF_FFF1,
               d_at, n_d, n_b, n_h, r_hi, r_lo, r_dbz);
        check_result("divu", 33, 33, 32'd2, 32'd14);
        run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, -1, -1, -1, 32'd2, 32'd14,
               d_at, n_d, n_b, n_h, r_hi, r_lo, r_dbz);
        check_result("div_neg", 33, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, -1, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
               d_at, n_d, n_b, n_h, r_hi, r_lo, r_dbz);
        check_result("div_ovf", 33, 33, 32'h0, 32'h8000_0000);
    endtask

    task automatic test_ignored_start();
        run_op(MD_DIVU, 32'd100, 32'd7, 5, 33, -1, 32'h0, 32'h8000_0000,
               d_at, n_d, n_b, n_h, r_hi, r_lo, r_dbz);
        check_result("busy_start", 33, 33, 32'd2, 32'd14);
    endtask

    task automatic test_back_to_back();
        int second_at;
        run_op(MD_DIVU, 32'd100, 32'd7, 34, -1, -1, 32'd2, 32'd14,
               d_at, n_d, n_b, n_h, r_hi, r_lo, r_dbz);
        check_result("b2b_first", 33, 39, 32'd2, 32'd14);
        second_at = -1;
        for (int k = 41; k <= 80; k++) begin
            if (md_bus.done) begin
                second_at = k; r_hi = md_bus.hi; r_lo = md_bus.lo;
                break;
            end
            @(negedge clk);
        end
        vectors++; if (second_at !== 67) begin miscompares++; $display("FAIL b2b_second_latency: got %0d want 67", second_at); end
        vectors++; if (r_hi !== 32'h0) begin miscompares++; $display("FAIL b2b_second_hi: got %h want 0", r_hi); end
        vectors++; if (r_lo !== 32'd6) begin miscompares++; $display("FAIL b2b_second_lo: got %h want 6", r_lo); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_mid_reset();
        run_op(MD_MULTU, 32'd6, 32'd7, -1, -1, 10, 32'h0, 32'd6,
               d_at, n_d, n_b, n_h, r_hi, r_lo, r_dbz);
        vectors++; if (n_d !== 0) begin miscompares++; $display("FAIL rst_abort_done: got %0d pulses want 0", n_d); end
        vectors++; if (n_b !== 10) begin miscompares++; $display("FAIL rst_abort_busy: got %0d want 10", n_b); end
        vectors++; if (md_bus.busy !== 1'b0) begin miscompares++; $display("FAIL rst_abort_busy_now: got %b want 0", md_bus.busy); end
        vectors++; if (md_bus.hi !== 32'h0) begin miscompares++; $display("FAIL rst_abort_hi: got %h want 0", md_bus.hi); end
        vectors++; if (md_bus.lo !== 32'h0) begin miscompares++; $display("FAIL rst_abort_lo: got %h want 0", md_bus.lo); end
        run_op(MD_MULTU, 32'd6, 32'd7, -1, -1, -1, 32'h0, 32'h0,
               d_at, n_d, n_b, n_h, r_hi, r_lo, r_dbz);
        check_result("after_rst", 33, 33, 32'h0, 32'd42);
    endtask

    task automatic test_div_by_zero();
        run_op(MD_DIVU, 32'd5, 32'd0, -1, -1, -1, 32'h0, 32'd42,
               d_at, n_d, n_b, n_h, r_hi, r_lo, r_dbz);
`ifdef MUL_DIV_DIVZERO_EN
        check_result("divzero", 1, 1, 32'h0, 32'd42);
        vectors++; if (r_dbz !== 1'b1) begin miscompares++; $display("FAIL divzero_flag: got %b want 1", r_dbz); end
        vectors++; if (md_bus.div_by_zero !== 1'b0) begin miscompares++; $display("FAIL divzero_flag_idle: got %b want 0", md_bus.div_by_zero); end
`else
        check_result("divzero", 33, 33, 32'd5, 32'hFFFF_FFFF);
`endif
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_multiply();
        test_divide();
        test_ignored_start();
        test_back_to_back();
        test_mid_reset();
        test_div_by_zero();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
